// File: rtl/seg_disp_decoder_if.sv
// Display-bus snoop interface: 2-digit multiplexed 7-segment lines in,
// decoded frame results out.
interface seg_disp_decoder_if;
    logic       CA;
    logic [6:0] AN;
    logic [3:0] NUM_1S;
    logic [3:0] NUM_10S;
    logic       VALID;
    logic       SEG_ERR;
    logic       LINK_LOST;

    // Bus driver / result consumer side
    modport master (
        output CA,
        output AN,
        input  NUM_1S,
        input  NUM_10S,
        input  VALID,
        input  SEG_ERR,
        input  LINK_LOST
    );

    // Decoder side
    modport slave (
        input  CA,
        input  AN,
        output NUM_1S,
        output NUM_10S,
        output VALID,
        output SEG_ERR,
        output LINK_LOST
    );
endinterface

// File: rtl/seg_disp_decoder.sv
// Receive-side decoder for a 2-digit multiplexed 7-segment bus. Waits for the
// segment lines to settle in each digit phase, decodes the pattern back to a
// nibble and publishes a coherent {tens, ones} pair once per frame.
module seg_disp_decoder #(
    parameter int unsigned STABLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic               CLK,
    input logic               RST,
    seg_disp_decoder_if.slave bus
);

    localparam int unsigned STAB_W = 8;
    localparam int unsigned TO_W   = 20;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYC);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic              ca_m, ca_s, ca_q;
    logic [6:0]        an_m, an_s, an_q;
    logic [STAB_W-1:0] stab_cnt;
    logic [TO_W-1:0]   to_cnt;
    state_t            state, state_d;

    logic [3:0]        ones_reg, ones_reg_d;
    logic              ones_ok, ones_ok_d;
    logic [3:0]        num_1s, num_1s_d;
    logic [3:0]        num_10s, num_10s_d;
    logic              valid, valid_d;
    logic              seg_err, seg_err_d;
    logic              link_lost, link_lost_d;

    logic              ca_edge;
    logic              an_chg;
    logic              settled;
    logic              timeout;
    logic [4:0]        dec;

    // Segment pattern -> {legal, nibble}; anything off-table (blank too) is illegal
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h58:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign ca_edge = (ca_s != ca_q);
    assign an_chg  = (an_s != an_q);
    // A CA edge in the same cycle pre-empts capture; so does a timeout
    assign timeout = !ca_edge && (to_cnt == TO_LAST);
    assign settled = !ca_edge && !an_chg && !timeout && (stab_cnt == STAB_LAST);
    assign dec     = seg_decode(an_s);

    // Two-flop synchronizers plus one delayed copy for change detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ca_m <= 1'b0;
            ca_s <= 1'b0;
            ca_q <= 1'b0;
            an_m <= 7'h00;
            an_s <= 7'h00;
            an_q <= 7'h00;
        end else begin
            ca_m <= bus.CA;
            ca_s <= ca_m;
            ca_q <= ca_s;
            an_m <= bus.AN;
            an_s <= an_m;
            an_q <= an_s;
        end
    end

    // Segment stability counter and link watchdog
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stab_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (ca_edge || an_chg) begin
                stab_cnt <= '0;
            end else if (stab_cnt < STAB_MAX) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end

            if (ca_edge) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, phase capture and frame assembly
    always_comb begin
        state_d     = state;
        ones_reg_d  = ones_reg;
        ones_ok_d   = ones_ok;
        num_1s_d    = num_1s;
        num_10s_d   = num_10s;
        valid_d     = 1'b0;
        seg_err_d   = 1'b0;
        link_lost_d = link_lost;

        if (ca_edge) begin
            link_lost_d = 1'b0;
        end

        if (timeout) begin
            state_d     = IDLE;
            ones_ok_d   = 1'b0;
            link_lost_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ca_edge) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (ca_edge) begin
                        // Phase ended before the segments settled: frame is broken
                        ones_ok_d = 1'b0;
                    end else if (settled) begin
                        state_d = HOLD;
                        if (!dec[4]) begin
                            seg_err_d = 1'b1;
                            ones_ok_d = 1'b0;
                        end else if (!ca_s) begin
                            ones_reg_d = dec[3:0];
                            ones_ok_d  = 1'b1;
                        end else begin
                            ones_ok_d = 1'b0;
                            if (ones_ok) begin
                                num_1s_d  = ones_reg;
                                num_10s_d = dec[3:0];
                                valid_d   = 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (ca_edge) begin
                        state_d = SETTLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame registers and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ones_reg  <= 4'h0;
            ones_ok   <= 1'b0;
            num_1s    <= 4'h0;
            num_10s   <= 4'h0;
            valid     <= 1'b0;
            seg_err   <= 1'b0;
            link_lost <= 1'b1;
        end else begin
            ones_reg  <= ones_reg_d;
            ones_ok   <= ones_ok_d;
            num_1s    <= num_1s_d;
            num_10s   <= num_10s_d;
            valid     <= valid_d;
            seg_err   <= seg_err_d;
            link_lost <= link_lost_d;
        end
    end

    assign bus.NUM_1S    = num_1s;
    assign bus.NUM_10S   = num_10s;
    assign bus.VALID     = valid;
    assign bus.SEG_ERR   = seg_err;
    assign bus.LINK_LOST = link_lost;

endmodule
